// File: rtl/sp_fifo_fwft_if.sv
// Stream handshake bundle for sp_fifo_fwft: RTS/RTR write and read sides
// plus flush and occupancy status.
interface sp_fifo_fwft_if #(
    parameter int WORDLENGTH = 8,
    parameter int DEPTH      = 5
);
    localparam int LW = $clog2(DEPTH + 1);

    logic                  IN_RTS;
    logic                  IN_RTR;
    logic [WORDLENGTH-1:0] IN_DAT;
    logic                  OUT_RTS;
    logic                  OUT_RTR;
    logic [WORDLENGTH-1:0] OUT_DAT;
    logic                  FLUSH;
    logic [LW-1:0]         LEVEL;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;

    modport master (
        output IN_RTS, IN_DAT, OUT_RTR, FLUSH,
        input  IN_RTR, OUT_RTS, OUT_DAT, LEVEL, ALMOST_FULL, ALMOST_EMPTY
    );

    modport slave (
        input  IN_RTS, IN_DAT, OUT_RTR, FLUSH,
        output IN_RTR, OUT_RTS, OUT_DAT, LEVEL, ALMOST_FULL, ALMOST_EMPTY
    );
endinterface

// File: rtl/sp_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with arbitrary depth, register
// array storage, occupancy reporting, almost flags and synchronous flush.
module sp_fifo_fwft #(
    parameter int WORDLENGTH = 8,
    parameter int DEPTH      = 5,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input logic             clk,
    input logic             reset,
    sp_fifo_fwft_if.slave   bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WORDLENGTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         wptr_next;
    logic [PW-1:0]         rptr_next;
    logic [LW-1:0]         level;
    logic                  in_rdy;
    logic                  out_rdy;
    logic                  in_xfc;
    logic                  out_xfc;

    // Ready flags depend only on registered state and the FLUSH/reset pins.
    always_comb begin
        in_rdy  = reset & ~bus.FLUSH & (level < LW'(DEPTH));
        out_rdy = reset & ~bus.FLUSH & (level != '0);
        in_xfc  = in_rdy & bus.IN_RTS;
        out_xfc = out_rdy & bus.OUT_RTR;
    end

    // Pointers wrap at DEPTH-1 so non-power-of-two depths never index past the array.
    always_comb begin
        wptr_next = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
        rptr_next = (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (in_xfc) begin
            mem[wptr] <= bus.IN_DAT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (bus.FLUSH) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (in_xfc) begin
                wptr <= wptr_next;
            end
            if (out_xfc) begin
                rptr <= rptr_next;
            end
            case ({in_xfc, out_xfc})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign bus.IN_RTR       = in_rdy;
    assign bus.OUT_RTS      = out_rdy;
    assign bus.OUT_DAT      = mem[rptr];
    assign bus.LEVEL        = level;
    assign bus.ALMOST_FULL  = (level >= LW'(AF_THRESH));
    assign bus.ALMOST_EMPTY = (level <= LW'(AE_THRESH));
endmodule

// File: tb/tb_sp_fifo_fwft.sv
// Scoreboard bench for sp_fifo_fwft: a queue model predicts readiness,
// occupancy, flags and the order of words leaving the FIFO.
module tb_sp_fifo_fwft;
    localparam int WORDLENGTH = 8;
    localparam int DEPTH      = 5;
    localparam int AF_THRESH  = DEPTH - 1;
    localparam int AE_THRESH  = 1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [WORDLENGTH-1:0] expQ [$];

    sp_fifo_fwft_if #(.WORDLENGTH(WORDLENGTH), .DEPTH(DEPTH)) bus ();

    sp_fifo_fwft #(
        .WORDLENGTH(WORDLENGTH),
        .DEPTH(DEPTH),
        .AF_THRESH(AF_THRESH),
        .AE_THRESH(AE_THRESH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Checks the DUT against the model before the edge, then advances the model.
    task automatic runCycle();
        logic expIn;
        logic expOut;
        int   lvl;
        @(negedge clk);
        lvl    = expQ.size();
        expIn  = reset && !bus.FLUSH && (lvl < DEPTH);
        expOut = reset && !bus.FLUSH && (lvl != 0);
        checkOutput("in_rtr", 32'(bus.IN_RTR), 32'(expIn));
        checkOutput("out_rts", 32'(bus.OUT_RTS), 32'(expOut));
        checkOutput("level", 32'(bus.LEVEL), 32'(lvl));
        checkOutput("almost_full", 32'(bus.ALMOST_FULL), 32'(lvl >= AF_THRESH));
        checkOutput("almost_empty", 32'(bus.ALMOST_EMPTY), 32'(lvl <= AE_THRESH));
        if (!reset) begin
            checkOutput("dat_in_reset", 32'(bus.OUT_DAT), 32'h0);
        end
        if (expOut && bus.OUT_RTR) begin
            checkOutput("pop_dat", 32'(bus.OUT_DAT), 32'(expQ.pop_front()));
        end else if (expOut) begin
            checkOutput("head_dat", 32'(bus.OUT_DAT), 32'(expQ[0]));
        end
        if (expIn && bus.IN_RTS) begin
            expQ.push_back(bus.IN_DAT);
        end
        if (!reset || bus.FLUSH) begin
            expQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rts, input logic [WORDLENGTH-1:0] dat,
                                 input logic rtr, input logic flush);
        bus.IN_RTS  = rts;
        bus.IN_DAT  = dat;
        bus.OUT_RTR = rtr;
        bus.FLUSH   = flush;
        runCycle();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.IN_RTS  = 1'b0;
        bus.IN_DAT  = '0;
        bus.OUT_RTR = 1'b0;
        bus.FLUSH   = 1'b0;

        $display("[TB] reset hold with writes requested");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        end
        reset = 1'b1;

        $display("[TB] fill and drain");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        end
        drain(6);

        $display("[TB] streaming across pointer wrap");
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, 8'(8'h22 + i), 1'b1, 1'b0);
        end

        $display("[TB] simultaneous read and write at full");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
        drain(6);

        $display("[TB] flush");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h5F, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        end
        reset = 1'b0;
        #1;
        checkOutput("async_level", 32'(bus.LEVEL), 32'h0);
        checkOutput("async_out_rts", 32'(bus.OUT_RTS), 32'h0);
        checkOutput("async_out_dat", 32'(bus.OUT_DAT), 32'h0);
        expQ.delete();
        applyStimulus(1'b1, 8'h6F, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h6E, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 8'h70, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h71, 1'b1, 1'b0);
        drain(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end
        drain(6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/sp_fifo_fwft.md
# sp_fifo_fwft

Parametrised synchronous FIFO with Selvaggi-style RTS/RTR ports on both sides, first-word-fall-through output, arbitrary (non-power-of-two) depth, occupancy reporting, almost-full/almost-empty flags and a synchronous flush. It is the next-generation drop-in for the single-clock stream buffers between pipeline stages. Unlike the earlier FIFO, it stores data in an internal register array with no external RAM model, and head data is valid on OUT_DAT whenever OUT_RTS is high.

## Interface
- WORDLENGTH, 8: data width in bits, ≥1.
- DEPTH, 5: number of storage words, ≥2, any integer (power of two not required).
- AF_THRESH, DEPTH-1: ALMOST_FULL asserts when level ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, 1: ALMOST_EMPTY asserts when level ≤ AE_THRESH; range 0..DEPTH-1.
- LW (derived, not overridable), $clog2(DEPTH+1): width of LEVEL.

- clk  input  1  rising-edge clock; only clock in the block.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- IN_RTS  input  1  upstream has a word to send.
- IN_RTR  output  1  FIFO can accept a word.
- IN_DAT  input  WORDLENGTH  write data, sampled on in-transfer.
- OUT_RTS  output  1  FIFO has a word; OUT_DAT is valid.
- OUT_RTR  input  1  downstream accepts a word.
- OUT_DAT  output  WORDLENGTH  head-of-queue data (fall-through).
- FLUSH  input  1  synchronous discard of all contents.
- LEVEL  output  LW  current occupancy, 0..DEPTH.
- ALMOST_FULL  output  1  LEVEL ≥ AF_THRESH.
- ALMOST_EMPTY  output  1  LEVEL ≤ AE_THRESH.

## Operation
- in_xfc = IN_RTS & IN_RTR; out_xfc = OUT_RTS & OUT_RTR. A transfer occurs only on a clk edge where the corresponding xfc is 1.
- IN_RTR = reset & !FLUSH & (level < DEPTH). OUT_RTS = reset & !FLUSH & (level != 0). Both are combinational from registered state and the FLUSH/reset pins only, never from IN_RTS or OUT_RTR.
- Storage: DEPTH × WORDLENGTH register array, with write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. It never passes through the values DEPTH..2^n-1.
- On in_xfc, mem[wptr] ← IN_DAT and wptr advances. On out_xfc, rptr advances.
- Level update:
  - in_xfc only: level +1.
  - out_xfc only: level −1.
  - Both or neither: level unchanged.
- OUT_DAT = mem[rptr] (combinational read). It is undefined to consumers when OUT_RTS = 0, but it is never X after reset.
- Full: IN_RTR = 0 even when OUT_RTR = 1 in the same cycle. There is no write-through on full.
- Empty: OUT_RTS = 0, so no read occurs and no bypass from IN_DAT to OUT_DAT exists.
- FLUSH = 1 at an edge: wptr, rptr and level are cleared to 0. Any IN_RTS/OUT_RTR activity in that cycle is ignored, since both ready outputs are forced low. Array contents are not cleared.
- Reset (asynchronous assertion) clears wptr, rptr, level and all array words to 0 immediately, without waiting for clk. Deassertion is sampled on the next clk edge, and normal operation resumes from that edge.
- Reset mid-operation drops every stored word. No transfer is counted on the edge where reset is low.

## Timing
- Output values while reset = 0:
  - IN_RTR 0, OUT_RTS 0, OUT_DAT 0.
  - LEVEL 0, ALMOST_FULL 0, ALMOST_EMPTY 1.
- First cycle after release: IN_RTR 1, OUT_RTS 0.
- Write-to-read latency is 1 cycle. A word accepted at edge N appears on OUT_DAT with OUT_RTS = 1 immediately after edge N, and can be consumed at edge N+1.
- Throughput is 1 word/cycle in and 1 word/cycle out, sustained, for any 0 < level < DEPTH.
- LEVEL, ALMOST_FULL and ALMOST_EMPTY update on the same edge as the transfer that changes level. They have no additional lag.
- FLUSH takes effect combinationally on the ready outputs and at the next edge on state. The cycle after FLUSH deasserts: LEVEL = 0, IN_RTR = 1.

## Test plan
- Reset/initial: hold reset = 0 for 3 cycles with IN_RTS = 1 -> IN_RTR = 0, OUT_RTS = 0, LEVEL = 0, ALMOST_EMPTY = 1. After release, IN_RTR = 1 next cycle.
- Fill/drain, DEPTH = 5: write 0x11..0x15 back-to-back with OUT_RTR = 0 -> LEVEL 1..5, ALMOST_FULL at LEVEL 4, IN_RTR = 0 at LEVEL 5, and a 6th write is not accepted. Then drain with OUT_RTR = 1 -> OUT_DAT 0x11..0x15 in order, OUT_RTS = 0 after the 5th read.
- Wrap-around: 13 streaming cycles with IN_RTS = OUT_RTR = 1 from LEVEL 2 -> LEVEL stays 2, data order preserved across pointer wrap 4→0, no gaps.
- Full simultaneous: at LEVEL 5, IN_RTS = 1 and OUT_RTR = 1 -> only the read occurs, LEVEL = 4. The next cycle, IN_RTR = 1 and the write is accepted.
- Flush: at LEVEL 3, assert FLUSH for 1 cycle with IN_RTS = 1 -> IN_RTR = OUT_RTS = 0 during FLUSH. Next cycle LEVEL = 0, and the first subsequent write appears on OUT_DAT after 1 cycle.
- Async reset mid-stream: pull reset low between edges at LEVEL 3 -> LEVEL, OUT_RTS and OUT_DAT go to 0 before the next clk edge, and no data from before reset reappears after release.
